// File: rtl/grant_decoder.sv
// Decodes an accepted 3-bit index into a one-hot grant and holds it until ack or timeout.
// Latency: grant is visible one cycle after the accepting edge; one all-zero RELEASE cycle follows every grant.
// Backpressure: in_ready is high only in IDLE, so at most one grant is outstanding and in_valid is ignored while busy.
module grant_decoder #(
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [IDX_W-1:0]      in_idx,
    output logic                  in_ready,
    input  logic                  ack,
    output logic [2**IDX_W-1:0]   grant,
    output logic                  busy,
    output logic                  timeout,
    output logic [IDX_W-1:0]      last_idx,
    output logic [7:0]            to_count
);

    localparam int GW = 2**IDX_W;
    localparam logic [GW-1:0]    ONE_HOT0 = GW'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_d;
    logic [GW-1:0]      grant_d;
    logic               timeout_d;
    logic [7:0]         to_count_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = last_idx;
        grant_d    = '0;
        timeout_d  = 1'b0;
        to_count_d = to_count;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_GRANT;
                    idx_d   = in_idx;
                    cnt_d   = '0;
                    grant_d = ONE_HOT0 << in_idx;
                end
            end
            ST_GRANT: begin
                // ack is checked before the counter so an ack in the last allowed cycle wins
                if (ack) begin
                    state_d = ST_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                    if (to_count != 8'hFF) begin
                        to_count_d = to_count + 8'd1;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    grant_d = ONE_HOT0 << last_idx;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_idx <= '0;
            grant    <= '0;
            timeout  <= 1'b0;
            to_count <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_idx <= idx_d;
            grant    <= grant_d;
            timeout  <= timeout_d;
            to_count <= to_count_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_GRANT) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_grant_decoder.sv
// Directed scoreboard bench for grant_decoder: expected outputs are queued per step and checked after the edge.
module tb_grant_decoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_idx;
    logic       in_ready;
    logic       ack;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;
    logic [2:0] last_idx;
    logic [7:0] to_count;

    int n_vec;
    int n_err;

    typedef struct packed {
        logic [7:0] g;
        logic       rdy;
        logic       bsy;
        logic       to;
        logic [2:0] li;
        logic [7:0] tc;
    } exp_t;

    exp_t sb[$];

    grant_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_idx   (in_idx),
        .in_ready (in_ready),
        .ack      (ack),
        .grant    (grant),
        .busy     (busy),
        .timeout  (timeout),
        .last_idx (last_idx),
        .to_count (to_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] g, input logic rdy, input logic bsy, input logic to,
                        input logic [2:0] li, input logic [7:0] tc);
        exp_t e;
        e.g = g; e.rdy = rdy; e.bsy = bsy; e.to = to; e.li = li; e.tc = tc;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".grant"},    grant,           e.g);
            chk({tag, ".in_ready"}, {7'd0, in_ready}, {7'd0, e.rdy});
            chk({tag, ".busy"},     {7'd0, busy},     {7'd0, e.bsy});
            chk({tag, ".timeout"},  {7'd0, timeout},  {7'd0, e.to});
            chk({tag, ".last_idx"}, {5'd0, last_idx}, {5'd0, e.li});
            chk({tag, ".to_count"}, to_count,         e.tc);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check the outputs produced by the next rising edge.
    task automatic cyc(input string tag, input logic v, input logic [2:0] idx, input logic a,
                       input logic [7:0] g, input logic rdy, input logic bsy, input logic to,
                       input logic [2:0] li, input logic [7:0] tc);
        in_valid = v;
        in_idx   = idx;
        ack      = a;
        push(g, rdy, bsy, to, li, tc);
        @(posedge clk);
        @(negedge clk);
        pop_check(tag);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_idx   = 3'd0;
        ack      = 1'b0;

        // reset then idle
        repeat (3) @(negedge clk);
        push(8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        pop_check("reset");
        rst_n = 1'b1;
        cyc("idle", 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        cyc("idle_ack", 1'b0, 3'd4, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);

        // basic grant idx 5, ack in third grant cycle
        cyc("basic_acc", 1'b1, 3'd5, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 3'd5, 8'd0);
        cyc("basic_g2",  1'b0, 3'd1, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 3'd5, 8'd0);
        cyc("basic_g3",  1'b0, 3'd1, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 3'd5, 8'd0);
        cyc("basic_rel", 1'b0, 3'd1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 8'd0);
        cyc("basic_idle", 1'b0, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'd0);

        // timeout: idx 0, no ack, 16 grant cycles
        cyc("to_acc", 1'b1, 3'd0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i < 15; i++)
            cyc("to_hold", 1'b0, 3'd0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        cyc("to_rel",  1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'd1);
        cyc("to_idle", 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);

        // ack in the 16th grant cycle wins over timeout
        cyc("b16_acc", 1'b1, 3'd3, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 3'd3, 8'd1);
        for (int i = 0; i < 15; i++)
            cyc("b16_hold", 1'b0, 3'd0, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 3'd3, 8'd1);
        cyc("b16_rel",  1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 8'd1);
        cyc("b16_idle", 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 8'd1);

        // ack in the first grant cycle
        cyc("b1_acc",  1'b1, 3'd6, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0, 3'd6, 8'd1);
        cyc("b1_rel",  1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd6, 8'd1);
        cyc("b1_idle", 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd6, 8'd1);

        // new requests ignored while busy
        cyc("busy_acc", 1'b1, 3'd7, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 3'd7, 8'd1);
        for (int i = 0; i < 3; i++)
            cyc("busy_hold", 1'b1, 3'd2, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 3'd7, 8'd1);
        cyc("busy_rel",  1'b1, 3'd2, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd7, 8'd1);
        cyc("busy_idle", 1'b1, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 8'd1);
        cyc("busy_acc2", 1'b1, 3'd2, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 3'd2, 8'd1);
        cyc("busy_rel2", 1'b0, 3'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'd1);
        cyc("busy_idle2", 1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'd1);

        // asynchronous reset between edges while grant = 0x08
        cyc("ar_acc",  1'b1, 3'd3, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 3'd3, 8'd1);
        cyc("ar_hold", 1'b0, 3'd0, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0, 3'd3, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        push(8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        pop_check("ar_async");
        @(negedge clk);
        rst_n = 1'b1;

        // sweep all indices with a zero cycle between grants
        for (int i = 0; i < 8; i++) begin
            logic [7:0] oh;
            oh = 8'd1 << i;
            cyc("sweep_acc",  1'b1, 3'(i), 1'b0, oh,    1'b0, 1'b1, 1'b0, 3'(i), 8'd0);
            cyc("sweep_rel",  1'b0, 3'd0,  1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 3'(i), 8'd0);
            cyc("sweep_idle", 1'b0, 3'd0,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'(i), 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/grant_decoder.md
Name: grant_decoder

Overview:
- Receive side of the 8-input priority encoder interface: accepts an encoded 3-bit index plus a valid flag, and drives the matching one-hot grant line.
- Holds the grant until the selected requester acknowledges it, or until a programmable timeout expires.
- Sits between the arbiter/encoder stage and the eight requester blocks.
- Ready/valid input handshake; at most one grant is outstanding at any time.

Parameters:
- IDX_W, 3, width of the encoded index; grant width is 2**IDX_W (8 by default).
- TIMEOUT, 16, maximum number of cycles a grant is held without ack; legal range 1 to 255.
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert is handled externally.
- in_valid  input  1  encoded index is valid (driven from the encoder's "d" flag).
- in_idx  input  IDX_W  encoded index of the winning requester.
- in_ready  output  1  decoder can accept a new index.
- ack  input  1  the granted requester has finished with the grant.
- grant  output  2**IDX_W  one-hot grant; all zero when no grant is active.
- busy  output  1  a grant is outstanding (state GRANT or RELEASE).
- timeout  output  1  one-cycle pulse: the last grant ended by timeout, not by ack.
- last_idx  output  IDX_W  index of the most recently accepted request.
- to_count  output  8  saturating count of timeouts since reset.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, grant = 0, in_ready = 1, busy = 0, timeout = 0, last_idx = 0, to_count = 0, hold counter = 0.
  - Reset mid-grant drops grant immediately, without waiting for a clock edge.
- State IDLE:
  - in_ready = 1, grant = 0, busy = 0.
  - Accept when in_valid && in_ready at edge T: latch in_idx into last_idx, clear hold counter, go to GRANT.
  - grant = 1 << last_idx becomes visible after edge T (1-cycle latency).
  - ack is ignored in IDLE.
- State GRANT:
  - in_ready = 0, busy = 1, grant is one-hot and stable.
  - in_valid is ignored; there is no queueing.
  - ack is sampled every GRANT cycle, including the first.
  - If ack = 1: go to RELEASE, timeout stays 0.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no ack: go to RELEASE, assert timeout for the single RELEASE cycle, and increment to_count (saturates at 255).
  - Grant is therefore held for between 1 and TIMEOUT cycles.
  - If ack arrives in the TIMEOUT-th cycle, ack wins and no timeout is raised.
- State RELEASE:
  - Exactly one cycle; grant = 0, busy = 1, in_ready = 0.
  - Go to IDLE unconditionally.
  - This guarantees at least one all-zero cycle between consecutive grants, even for the same index.
- Back-to-back rate: one grant per TIMEOUT+2 cycles worst case, 3 cycles best case (accept, grant+ack, release).
- Output timing:
  - All outputs are registered, except in_ready and busy, which are decoded from the state register.
  - grant never carries more than one hot bit.
- in_idx is sampled only on the accepting edge; changes at any other time have no effect.
- Unused state encodings recover to IDLE with grant = 0.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high with in_valid = 0 -> grant = 0x00, in_ready = 1, busy = 0, to_count = 0.
- Basic grant: in_valid = 1, in_idx = 5 at edge T, ack pulsed at edge T+3 -> grant = 0x20 in cycles T+1..T+3, 0x00 at T+4 (RELEASE), in_ready = 1 at T+5, last_idx = 5, timeout never asserted.
- Timeout: in_idx = 0 accepted, no ack, TIMEOUT = 16 -> grant = 0x01 for exactly 16 cycles, then a 1-cycle timeout pulse with grant = 0x00, to_count = 1.
- Ack on the boundary: ack in the 16th grant cycle -> no timeout pulse, to_count unchanged. Separately, ack in the first grant cycle -> grant high for 1 cycle only.
- Input ignored while busy: accept idx 7, then drive in_valid = 1, in_idx = 2 throughout GRANT -> grant stays 0x80. After RELEASE and IDLE, idx 2 is accepted and grant = 0x04.
- Async reset mid-grant: assert rst_n low between clock edges while grant = 0x08 -> grant = 0x00 immediately. After release, a full sweep of idx 0..7 produces grants 0x01..0x80 with a zero cycle between each.
